// File: rtl/mac_scheduler.sv
// rtl/mac_scheduler.sv - round-robin sequencer sharing one multiply-accumulate datapath among NREQ requesters
// Optional stall timeout: define MAC_SCHED_TIMEOUT_EN.
module mac_scheduler #(
    parameter int NREQ    = 2,
    parameter int COUNT   = 4,
    parameter int W       = 20,
    parameter int ACC_W   = 42,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    input  logic [NREQ-1:0]     op_valid,
    output logic [NREQ-1:0]     op_ready,
    input  logic [NREQ*W-1:0]   op_a,
    input  logic [NREQ*W-1:0]   op_b,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [ACC_W-1:0]    result_data,
    output logic [1:0]          result_id,
    output logic                result_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_RESULT
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        gidx_q, gidx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ACC_W-1:0]  res_data_q, res_data_d;
    logic [1:0]        res_id_q, res_id_d;
    logic              res_valid_q, res_valid_d;
    logic              res_err_q, res_err_d;

`ifdef MAC_SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0]     stall_q, stall_d;
`endif

    logic [NREQ-1:0]   win_oh;
    logic [1:0]        win_idx;
    logic [W-1:0]      a_sel, b_sel;
    logic [2*W-1:0]    prod_raw;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  acc_sum;
    logic              beat;

    // Winner is the requester at the smallest rotational distance past last_q.
    always_comb begin : arb
        int best_d;
        int d;
        win_oh  = '0;
        win_idx = '0;
        best_d  = NREQ;
        d       = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - 1 - int'(last_q)) % NREQ;
            if (req[i] && d < best_d) begin
                best_d     = d;
                win_oh     = '0;
                win_oh[i]  = 1'b1;
                win_idx    = 2'(i);
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                a_sel = op_a[i*W +: W];
                b_sel = op_b[i*W +: W];
            end
        end
        prod_raw = {{W{1'b0}}, a_sel} * {{W{1'b0}}, b_sel};
        prod     = ACC_W'(prod_raw);
        acc_sum  = acc_q + prod;
    end

    assign op_ready = (state_q == ST_BURST) ? gnt_q : '0;
    assign beat     = |(op_valid & op_ready);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        gidx_d      = gidx_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
`ifdef MAC_SCHED_TIMEOUT_EN
        stall_d     = stall_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = win_oh;
                    last_d  = win_idx;
                    gidx_d  = win_idx;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BURST;
`ifdef MAC_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            ST_BURST: begin
                if (beat) begin
`ifdef MAC_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (cnt_q == 4'(COUNT - 1)) begin
                        res_data_d  = acc_sum;
                        res_id_d    = gidx_q;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b0;
                        state_d     = ST_RESULT;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef MAC_SCHED_TIMEOUT_EN
                // Abort with the partial sum once the stall run hits the limit.
                else if (stall_q == SW'(TIMEOUT - 1)) begin
                    res_data_d  = acc_q;
                    res_id_d    = gidx_q;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    state_d     = ST_RESULT;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
`endif
            end
            ST_RESULT: begin
                if (result_ready) begin
                    res_valid_d = 1'b0;
                    gnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            last_q      <= 2'(NREQ - 1);
            gidx_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            gidx_q      <= gidx_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
        end
    end

`ifdef MAC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign gnt          = gnt_q;
    assign result_valid = res_valid_q;
    assign result_data  = res_data_q;
    assign result_id    = res_id_q;
    assign result_err   = res_err_q;

endmodule
